// File: rtl/rv32ima_pkg.sv
// Shared types for the RV32IMA core and its memory-side models.
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ram_state_t;

    localparam word_t DEFAULT_TO_HOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/ram_responder_array.sv
// DEPTH x 32 single-port synchronous word array with registered read data.
// The read register also carries the responder's ram_load reset and tohost-read clear.
module ram_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     we,
    input  logic                     re,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q <= '0;
        end else if (clr) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the core's single-port RAM interface, with tohost mailbox.
// Optional RAM_PERF_EN adds saturating read/write/error counters.
module ram_responder
    import rv32ima_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned LAT          = 2,
    parameter word_t       TO_HOST_ADDR = DEFAULT_TO_HOST_ADDR
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ram_ren,
    input  logic       ram_wen,
    input  word_t      ram_addr,
    input  word_t      ram_store,
    output ram_state_t ram_state,
    output word_t      ram_load,
    output word_t      tohost_data,
    output logic       tohost_valid
`ifdef RAM_PERF_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAcc, StErr} fsm_t;

    fsm_t        state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    word_t       req_addr_q, req_store_q;
    logic        req_ren_q, req_wen_q;
    word_t       tohost_data_q;
    logic        tohost_valid_q;

    logic        latch, enter_acc, bad_req, mismatch;
    word_t       acc_addr, acc_store;
    logic        acc_ren, acc_wen, is_tohost;
    logic        mem_we, mem_re, load_clr;

    assign bad_req = (ram_ren && ram_wen) || (ram_addr[1:0] != 2'b00) ||
                     (((ram_addr >> 2) >= DEPTH) && (ram_addr != TO_HOST_ADDR));

    assign mismatch = !(ram_ren || ram_wen) || (ram_addr != req_addr_q) ||
                      (ram_ren != req_ren_q) || (ram_wen != req_wen_q) ||
                      (req_wen_q && (ram_store != req_store_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        enter_acc = 1'b0;
        acc_addr  = req_addr_q;
        acc_store = req_store_q;
        acc_ren   = req_ren_q;
        acc_wen   = req_wen_q;
        case (state_q)
            StIdle: begin
                // With LAT==0 the access is served straight from the live request.
                acc_addr  = ram_addr;
                acc_store = ram_store;
                acc_ren   = ram_ren;
                acc_wen   = ram_wen;
                if (ram_ren || ram_wen) begin
                    if (bad_req) begin
                        state_d = StErr;
                    end else begin
                        latch = 1'b1;
                        if (LAT == 0) begin
                            state_d   = StAcc;
                            enter_acc = 1'b1;
                        end else begin
                            state_d = StWait;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            StWait: begin
                if (mismatch) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d   = StAcc;
                    enter_acc = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign is_tohost = (acc_addr == TO_HOST_ADDR);
    assign mem_we    = enter_acc && acc_wen && !is_tohost;
    assign mem_re    = enter_acc && acc_ren && !is_tohost;
    assign load_clr  = enter_acc && acc_ren && is_tohost;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            req_addr_q     <= '0;
            req_store_q    <= '0;
            req_ren_q      <= 1'b0;
            req_wen_q      <= 1'b0;
            tohost_data_q  <= '0;
            tohost_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                req_addr_q  <= ram_addr;
                req_store_q <= ram_store;
                req_ren_q   <= ram_ren;
                req_wen_q   <= ram_wen;
            end
            if (enter_acc && acc_wen && is_tohost) begin
                tohost_data_q  <= acc_store;
                tohost_valid_q <= 1'b1;
            end
        end
    end

    ram_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk),
        .nrst  (nrst),
        .we    (mem_we),
        .re    (mem_re),
        .clr   (load_clr),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_store),
        .rdata (ram_load)
    );

    always_comb begin
        ram_state = FREE;
        case (state_q)
            StWait:  ram_state = BUSY;
            StAcc:   ram_state = ACCESS;
            StErr:   ram_state = ERROR;
            default: ram_state = FREE;
        endcase
    end

    assign tohost_data  = tohost_data_q;
    assign tohost_valid = tohost_valid_q;

`ifdef RAM_PERF_EN
    logic [31:0] rd_count_q, wr_count_q;
    logic [15:0] err_count_q;
    logic        enter_err;

    assign enter_err = (state_q == StIdle) && (state_d == StErr);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (enter_acc && acc_ren && (rd_count_q != '1)) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (enter_acc && acc_wen && (wr_count_q != '1)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (enter_err && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus a randomized run
// checked against a transaction-level model. Define RAM_PERF_EN to also check counters.
`timescale 1ns/1ps
module tb_ram_responder;
    import rv32ima_pkg::*;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned LAT    = 2;
    localparam word_t       TOHOST = 32'h0000_1000;

    logic       clk      = 1'b0;
    logic       nrst     = 1'b1;
    logic       ram_ren  = 1'b0;
    logic       ram_wen  = 1'b0;
    word_t      ram_addr = '0;
    word_t      ram_store = '0;
    ram_state_t ram_state;
    word_t      ram_load;
    word_t      tohost_data;
    logic       tohost_valid;
`ifdef RAM_PERF_EN
    logic [31:0] rd_count, wr_count;
    logic [15:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    // Transaction-level model state.
    word_t mdl_mem [int unsigned];
    word_t mdl_load = '0;
    word_t th_data  = '0;
    logic  th_valid = 1'b0;
    int    n_rd = 0, n_wr = 0, n_err = 0;

    always #5 clk = ~clk;

    ram_responder #(
        .DEPTH        (DEPTH),
        .LAT          (LAT),
        .TO_HOST_ADDR (TOHOST)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .ram_ren      (ram_ren),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_store    (ram_store),
        .ram_state    (ram_state),
        .ram_load     (ram_load),
        .tohost_data  (tohost_data),
        .tohost_valid (tohost_valid)
`ifdef RAM_PERF_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .err_count    (err_count)
`endif
    );

    task automatic model_reset();
        mdl_load = '0;
        th_data  = '0;
        th_valid = 1'b0;
        n_rd = 0;
        n_wr = 0;
        n_err = 0;
    endtask

    // Applies one transaction to the model and returns what the bus should show.
    task automatic model_txn(input logic r, input logic w, input word_t a, input word_t s,
                             output ram_state_t exp_fin, output int exp_busy,
                             output word_t exp_load);
        logic bad;
        bad = (r && w) || (a[1:0] != 2'b00) || (((a >> 2) >= DEPTH) && (a != TOHOST));
        if (bad) begin
            exp_fin  = ERROR;
            exp_busy = 0;
            n_err++;
        end else begin
            exp_fin  = ACCESS;
            exp_busy = int'(LAT);
            if (r) begin
                if (a == TOHOST) mdl_load = '0;
                else mdl_load = mdl_mem.exists(a >> 2) ? mdl_mem[a >> 2] : '0;
                n_rd++;
            end else begin
                if (a == TOHOST) begin
                    th_data  = s;
                    th_valid = 1'b1;
                end else begin
                    mdl_mem[a >> 2] = s;
                end
                n_wr++;
            end
        end
        exp_load = mdl_load;
    endtask

    // Drives one request from a negedge, holds it until ACCESS/ERROR, drops it,
    // and returns one cycle later at a negedge.
    task automatic run_req(input logic r, input logic w, input word_t a, input word_t s,
                           output int busy, output ram_state_t fin, output word_t load);
        ram_ren = r;
        ram_wen = w;
        ram_addr = a;
        ram_store = s;
        busy = 0;
        fin = BUSY;
        load = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_state == BUSY) begin
                busy++;
            end else begin
                fin = ram_state;
                load = ram_load;
                break;
            end
        end
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 nrst = 1'b0;
        #1;
        checks++;
        if (ram_state !== FREE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", ram_state, FREE);
        end
        checks++;
        if (ram_load !== 32'h0 || tohost_data !== 32'h0 || tohost_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: load=%h th_data=%h th_valid=%b want 0/0/0",
                     ram_load, tohost_data, tohost_valid);
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (ram_state !== FREE) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d want %0d", ram_state, FREE);
        end
    endtask

    task automatic test_write_read();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        model_txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, busy, fin, load);
        checks++;
        if (fin !== ACCESS || busy != int'(LAT)) begin
            errors++;
            $display("FAIL wr_latency: got state=%0d busy=%0d want state=%0d busy=%0d",
                     fin, busy, ACCESS, LAT);
        end
        model_txn(1'b1, 1'b0, 32'h10, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, busy, fin, load);
        checks++;
        if (fin !== ACCESS || busy != int'(LAT)) begin
            errors++;
            $display("FAIL rd_latency: got state=%0d busy=%0d want state=%0d busy=%0d",
                     fin, busy, ACCESS, LAT);
        end
        checks++;
        if (load !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_data: got %h want %h", load, 32'hDEAD_BEEF);
        end
        checks++;
        if (ram_state !== FREE) begin
            errors++;
            $display("FAIL free_after_acc: got %0d want %0d", ram_state, FREE);
        end
    endtask

    task automatic test_load_after_write();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        model_txn(1'b0, 1'b1, 32'h0, 32'h1234_5678, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h0, 32'h1234_5678, busy, fin, load);
        checks++;
        if (load !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_keeps_load: got %h want %h", load, 32'hDEAD_BEEF);
        end
        model_txn(1'b1, 1'b0, 32'h0, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h0, 32'h0, busy, fin, load);
        checks++;
        if (fin !== ACCESS || load !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_addr0: got state=%0d load=%h want state=%0d load=%h",
                     fin, load, ACCESS, 32'h1234_5678);
        end
    endtask

    task automatic test_errors();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        logic  er [4];
        logic  ew [4];
        word_t ea [4];
        er = '{1'b1, 1'b1, 1'b1, 1'b0};
        ew = '{1'b1, 1'b0, 1'b0, 1'b1};
        ea = '{32'h20, 32'h22, 32'h4000, 32'h2000};
        model_txn(1'b0, 1'b1, 32'h20, 32'hA5A5_0020, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h20, 32'hA5A5_0020, busy, fin, load);
        for (int i = 0; i < 4; i++) begin
            model_txn(er[i], ew[i], ea[i], 32'hBAD0_0000 + i, ef, eb, el);
            run_req(er[i], ew[i], ea[i], 32'hBAD0_0000 + i, busy, fin, load);
            checks++;
            if (fin !== ERROR || busy != 0) begin
                errors++;
                $display("FAIL err_case%0d: got state=%0d busy=%0d want state=%0d busy=0",
                         i, fin, busy, ERROR);
            end
            checks++;
            if (ram_state !== FREE) begin
                errors++;
                $display("FAIL err_case%0d_free: got %0d want %0d", i, ram_state, FREE);
            end
        end
        model_txn(1'b1, 1'b0, 32'h20, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h20, 32'h0, busy, fin, load);
        checks++;
        if (load !== 32'hA5A5_0020) begin
            errors++;
            $display("FAIL err_mem_20: got %h want %h", load, 32'hA5A5_0020);
        end
        model_txn(1'b1, 1'b0, 32'h0, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h0, 32'h0, busy, fin, load);
        checks++;
        if (load !== 32'h1234_5678) begin
            errors++;
            $display("FAIL err_mem_alias: got %h want %h", load, 32'h1234_5678);
        end
    endtask

    task automatic test_tohost();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        model_txn(1'b0, 1'b1, TOHOST, 32'h1, ef, eb, el);
        run_req(1'b0, 1'b1, TOHOST, 32'h1, busy, fin, load);
        checks++;
        if (fin !== ACCESS || tohost_valid !== 1'b1 || tohost_data !== 32'h1) begin
            errors++;
            $display("FAIL tohost_first: got state=%0d valid=%b data=%h want %0d/1/1",
                     fin, tohost_valid, tohost_data, ACCESS);
        end
        model_txn(1'b0, 1'b1, TOHOST, 32'h7, ef, eb, el);
        run_req(1'b0, 1'b1, TOHOST, 32'h7, busy, fin, load);
        checks++;
        if (tohost_valid !== 1'b1 || tohost_data !== 32'h7) begin
            errors++;
            $display("FAIL tohost_second: got valid=%b data=%h want 1/7",
                     tohost_valid, tohost_data);
        end
        model_txn(1'b1, 1'b0, TOHOST, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, TOHOST, 32'h0, busy, fin, load);
        checks++;
        if (fin !== ACCESS || load !== 32'h0) begin
            errors++;
            $display("FAIL tohost_read: got state=%0d load=%h want %0d/0", fin, load, ACCESS);
        end
        // Mailbox index aliases onto word 0; the array must be untouched.
        model_txn(1'b1, 1'b0, 32'h0, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h0, 32'h0, busy, fin, load);
        checks++;
        if (load !== 32'h1234_5678) begin
            errors++;
            $display("FAIL tohost_no_mem: got %h want %h", load, 32'h1234_5678);
        end
    endtask

    task automatic test_perf();
`ifdef RAM_PERF_EN
        checks++;
        if (rd_count !== 32'(n_rd) || wr_count !== 32'(n_wr) || err_count !== 16'(n_err)) begin
            errors++;
            $display("FAIL perf_counts: got rd=%0d wr=%0d err=%0d want rd=%0d wr=%0d err=%0d",
                     rd_count, wr_count, err_count, n_rd, n_wr, n_err);
        end
`endif
    endtask

    task automatic test_abort();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        model_txn(1'b0, 1'b1, 32'h40, 32'h4040_4040, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h40, 32'h4040_4040, busy, fin, load);
        model_txn(1'b0, 1'b1, 32'h44, 32'h4444_4444, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h44, 32'h4444_4444, busy, fin, load);
        ram_ren = 1'b1;
        ram_wen = 1'b0;
        ram_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (ram_state !== BUSY) begin
            errors++;
            $display("FAIL abort_busy: got %0d want %0d", ram_state, BUSY);
        end
        ram_addr = 32'h44;
        @(negedge clk);
        checks++;
        if (ram_state !== FREE) begin
            errors++;
            $display("FAIL abort_free: got %0d want %0d", ram_state, FREE);
        end
        model_txn(1'b1, 1'b0, 32'h44, 32'h0, ef, eb, el);
        busy = 0;
        fin = BUSY;
        load = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_state == BUSY) begin
                busy++;
            end else begin
                fin = ram_state;
                load = ram_load;
                break;
            end
        end
        ram_ren = 1'b0;
        @(negedge clk);
        checks++;
        if (fin !== ACCESS || busy != int'(LAT) || load !== 32'h4444_4444) begin
            errors++;
            $display("FAIL abort_retry: got state=%0d busy=%0d load=%h want %0d/%0d/%h",
                     fin, busy, load, ACCESS, LAT, 32'h4444_4444);
        end
        test_perf();
    endtask

    task automatic test_random();
        int busy, eb, op, idx;
        ram_state_t fin, ef;
        word_t load, el, a, s;
        logic r, w;
        word_t written [$];
        for (int t = 0; t < 60; t++) begin
            op  = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 63));
            s   = $urandom;
            r = 1'b0;
            w = 1'b1;
            a = 32'(idx) << 2;
            if (op >= 4 && op <= 6 && written.size() > 0) begin
                r = 1'b1;
                w = 1'b0;
                a = written[$urandom_range(0, written.size() - 1)];
            end else if (op == 7) begin
                case (idx % 3)
                    0: begin r = 1'b1; w = 1'b1; end
                    1: begin r = 1'b1; w = 1'b0; a = a + 32'(1 + idx % 3); end
                    default: a = 32'h2000 + a;
                endcase
            end else if (op == 8) begin
                a = TOHOST;
            end else if (op == 9) begin
                r = 1'b1;
                w = 1'b0;
                a = TOHOST;
            end
            if (w && !r && a[1:0] == 2'b00 && a < 32'h100) written.push_back(a);
            model_txn(r, w, a, s, ef, eb, el);
            run_req(r, w, a, s, busy, fin, load);
            checks++;
            if (fin !== ef || busy != eb || load !== el) begin
                errors++;
                $display("FAIL rand%0d r=%b w=%b a=%h: got %0d/%0d/%h want %0d/%0d/%h",
                         t, r, w, a, fin, busy, load, ef, eb, el);
            end
            checks++;
            if (tohost_valid !== th_valid || tohost_data !== th_data) begin
                errors++;
                $display("FAIL rand%0d_tohost: got %b/%h want %b/%h",
                         t, tohost_valid, tohost_data, th_valid, th_data);
            end
        end
        test_perf();
    endtask

    task automatic test_reset_mid_wait();
        int busy, eb;
        ram_state_t fin, ef;
        word_t load, el;
        model_txn(1'b0, 1'b1, 32'h80, 32'h1111_1111, ef, eb, el);
        run_req(1'b0, 1'b1, 32'h80, 32'h1111_1111, busy, fin, load);
        model_txn(1'b1, 1'b0, 32'h80, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h80, 32'h0, busy, fin, load);
        ram_wen = 1'b1;
        ram_addr = 32'h80;
        ram_store = 32'hCAFE_BABE;
        @(negedge clk);
        checks++;
        if (ram_state !== BUSY) begin
            errors++;
            $display("FAIL midwait_busy: got %0d want %0d", ram_state, BUSY);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (ram_state !== FREE || ram_load !== 32'h0) begin
            errors++;
            $display("FAIL midwait_reset: got state=%0d load=%h want %0d/0",
                     ram_state, ram_load, FREE);
        end
        checks++;
        if (tohost_valid !== 1'b0 || tohost_data !== 32'h0) begin
            errors++;
            $display("FAIL midwait_tohost: got %b/%h want 0/0", tohost_valid, tohost_data);
        end
        ram_wen = 1'b0;
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        model_txn(1'b1, 1'b0, 32'h80, 32'h0, ef, eb, el);
        run_req(1'b1, 1'b0, 32'h80, 32'h0, busy, fin, load);
        checks++;
        if (fin !== ACCESS || load !== 32'h1111_1111) begin
            errors++;
            $display("FAIL midwait_no_write: got %0d/%h want %0d/%h",
                     fin, load, ACCESS, 32'h1111_1111);
        end
        test_perf();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_after_write();
        test_errors();
        test_tohost();
        test_abort();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
